// File: rtl/sprom_burst_reader.sv
// Burst read controller for a fixed-latency single-port ROM.
// Credit-limited issue keeps the return FIFO from overflowing under backpressure.
module sprom_burst_reader #(
  parameter int ADDR_WIDTH_A      = 6,
  parameter int READ_DATA_WIDTH_A = 32,
  parameter int READ_LATENCY_A    = 2
) (
  input  logic                         clka,
  input  logic                         rsta,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [ADDR_WIDTH_A-1:0]      cmd_addr,
  input  logic [ADDR_WIDTH_A:0]        cmd_len,
  output logic                         ena,
  output logic [ADDR_WIDTH_A-1:0]      addra,
  output logic                         regcea,
  input  logic [READ_DATA_WIDTH_A-1:0] douta,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [READ_DATA_WIDTH_A-1:0] m_data,
  output logic                         m_last,
  output logic                         busy,
  output logic                         done
);

  localparam int AW = ADDR_WIDTH_A;
  localparam int DW = READ_DATA_WIDTH_A;
  localparam int L  = READ_LATENCY_A;
  localparam int FIFO_DEPTH = L + 2;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [AW-1:0] addr_cnt;
  logic [AW-1:0] addr_last;
  logic [AW:0]   remaining;
  logic [L-1:0]  sr_v;
  logic [L-1:0]  sr_l;
  logic [DW:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] in_flight;
  logic [CW:0]   outstanding;
  logic          credit_ok;
  logic          accept;
  logic          issue;
  logic          issue_last;
  logic          push;
  logic          pop;
  logic          last_pop;

  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Words already requested from the ROM but not yet captured.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < L; i++) begin
      in_flight = in_flight + CW'(sr_v[i]);
    end
  end

  assign outstanding = {1'b0, in_flight} + {1'b0, fifo_count};
  assign credit_ok   = outstanding < (CW+1)'(FIFO_DEPTH);
  assign accept      = cmd_valid & cmd_ready;
  assign issue_last  = issue & (remaining == (AW+1)'(1));
  assign push        = sr_v[L-1];
  assign pop         = m_valid & m_ready;
  assign last_pop    = pop & m_last;

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept && cmd_len != '0) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (issue_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (last_pop) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b1;
    issue     = 1'b0;
    unique case (1'b1)
      state_q == IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      state_q == ISSUE: issue = credit_ok;
      default: ;
    endcase
  end

  assign ena     = issue;
  assign addra   = issue ? addr_cnt : addr_last;
  assign regcea  = ~rsta;
  assign m_valid = fifo_count != '0;
  assign m_data  = fifo_mem[rd_ptr][DW-1:0];
  assign m_last  = fifo_mem[rd_ptr][DW];

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      addr_cnt   <= '0;
      addr_last  <= '0;
      remaining  <= '0;
      sr_v       <= '0;
      sr_l       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      done       <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      if (accept) begin
        addr_cnt  <= cmd_addr;
        remaining <= cmd_len;
      end else if (issue) begin
        addr_cnt  <= addr_cnt + 1'b1;
        remaining <= remaining - 1'b1;
      end
      if (issue) begin
        addr_last <= addr_cnt;
      end
      // Mirrors the ROM pipeline so captures line up with douta.
      sr_v <= (sr_v << 1) | L'(issue);
      sr_l <= (sr_l << 1) | L'(issue_last);
      if (push) begin
        fifo_mem[wr_ptr] <= {sr_l[L-1], douta};
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (push && !pop) begin
        fifo_count <= fifo_count + 1'b1;
      end else if (pop && !push) begin
        fifo_count <= fifo_count - 1'b1;
      end
      done <= ((state_q == DRAIN) & last_pop)
            | (accept & (cmd_len == '0));
    end
  end

endmodule

// File: tb/tb_sprom_burst_reader.sv
// Directed bench for sprom_burst_reader with behavioural ROM models.
// Main instance uses L=2; three extra instances sweep L=1,3,5.
module tb_sprom_burst_reader;

  localparam int AW = 6;
  localparam int DW = 32;

  logic clka = 1'b0;
  logic rsta = 1'b1;
  always #5 clka = ~clka;

  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [AW:0]   cmd_len;
  logic          ena;
  logic [AW-1:0] addra;
  logic          regcea;
  logic [DW-1:0] douta;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic          done;
  logic          sw_valid;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return 32'hA500_0000 | {26'd0, a};
  endfunction

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clka) cyc <= cyc + 1;

  logic [DW-1:0] rom_p [2];
  always @(posedge clka) begin
    if (regcea) begin
      if (ena) rom_p[0] <= rom_word(addra);
      rom_p[1] <= rom_p[0];
    end
  end
  assign douta = rom_p[1];

  sprom_burst_reader #(
    .ADDR_WIDTH_A(AW),
    .READ_DATA_WIDTH_A(DW),
    .READ_LATENCY_A(2)
  ) u_dut (
    .clka(clka), .rsta(rsta),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .ena(ena), .addra(addra), .regcea(regcea), .douta(douta),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .busy(busy), .done(done)
  );

  int acc_cyc  = 0;
  int done_n   = 0;
  int done_cyc = 0;
  int iss_n    = 0;
  int pop_n    = 0;
  int out_max  = 0;
  logic [DW-1:0] q_d [$];
  logic          q_l [$];
  int            q_c [$];

  always @(negedge clka) begin
    if (rsta) begin
      iss_n = 0;
      pop_n = 0;
    end else begin
      if (cmd_valid && cmd_ready) acc_cyc = cyc + 1;
      if (ena) iss_n++;
      if (m_valid && m_ready) begin
        q_d.push_back(m_data);
        q_l.push_back(m_last);
        q_c.push_back(cyc);
        pop_n++;
      end
      if (iss_n - pop_n > out_max) out_max = iss_n - pop_n;
      if (done) begin
        done_n++;
        done_cyc = cyc;
      end
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_sw
    localparam int LV = (g == 0) ? 1 : ((g == 1) ? 3 : 5);
    logic          s_cmd_ready, s_ena, s_regcea, s_m_valid;
    logic          s_m_last, s_busy, s_done;
    logic [AW-1:0] s_addra;
    logic [DW-1:0] s_douta, s_m_data;
    logic [DW-1:0] p [LV];
    int acc = 0, first = -1, n = 0, lastc = 0, good = 0;

    always @(posedge clka) begin
      if (s_regcea) begin
        if (s_ena) p[0] <= rom_word(s_addra);
        for (int i = 1; i < LV; i++) p[i] <= p[i-1];
      end
    end
    assign s_douta = p[LV-1];

    always @(negedge clka) begin
      if (!rsta) begin
        if (sw_valid && s_cmd_ready) acc = cyc + 1;
        if (s_m_valid) begin
          if (first < 0) first = cyc;
          lastc = cyc;
          if (s_m_data === rom_word(AW'(n)) && s_m_last === (n == 3))
            good++;
          n++;
        end
      end
    end

    sprom_burst_reader #(
      .ADDR_WIDTH_A(AW),
      .READ_DATA_WIDTH_A(DW),
      .READ_LATENCY_A(LV)
    ) u_sw (
      .clka(clka), .rsta(rsta),
      .cmd_valid(sw_valid), .cmd_ready(s_cmd_ready),
      .cmd_addr(6'd0), .cmd_len(7'd4),
      .ena(s_ena), .addra(s_addra), .regcea(s_regcea), .douta(s_douta),
      .m_valid(s_m_valid), .m_ready(1'b1), .m_data(s_m_data),
      .m_last(s_m_last), .busy(s_busy), .done(s_done)
    );
  end

  task automatic run_cmd(input logic [AW-1:0] a, input logic [AW:0] l,
                         input bit sw);
    @(posedge clka);
    #1;
    cmd_addr  = a;
    cmd_len   = l;
    cmd_valid = 1'b1;
    sw_valid  = sw;
    for (int i = 0; i < 20; i++) begin
      @(negedge clka);
      if (cmd_ready) break;
    end
    if (!cmd_ready) check("cmd_accept_timeout", 0, 1);
    @(posedge clka);
    #1;
    cmd_valid = 1'b0;
    sw_valid  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0;
    int i;
    d0 = done_n;
    i  = 0;
    while (done_n == d0 && i < budget) begin
      @(posedge clka);
      #1;
      i++;
    end
    check(tag, done_n != d0, 1);
  endtask

  task automatic chk_burst(input string tag, input int base,
                           input logic [AW-1:0] a0, input int n);
    logic [AW-1:0] a;
    check({tag, "_beats"}, q_d.size() - base, n);
    for (int i = 0; i < n; i++) begin
      if (base + i < q_d.size()) begin
        a = a0 + AW'(i);
        check({tag, "_data"}, q_d[base+i], rom_word(a));
        check({tag, "_last"}, q_l[base+i], i == n - 1);
      end
    end
  endtask

  task automatic chk_sweep(input string tag, input int lv, input int acc,
                           input int first, input int n, input int lastc,
                           input int good);
    check({tag, "_latency"}, first - acc, lv + 1);
    check({tag, "_beats"}, n, 4);
    check({tag, "_data_ok"}, good, 4);
    check({tag, "_tput"}, lastc - first, 3);
  endtask

  initial begin
    int b;
    int d0;
    int e0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    m_ready   = 1'b0;
    sw_valid  = 1'b0;

    repeat (3) @(posedge clka);
    @(negedge clka);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_ena", ena, 0);
    check("rst_addra", addra, 0);
    check("rst_regcea", regcea, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_last", m_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(posedge clka);
    #1;
    rsta = 1'b0;
    @(negedge clka);
    check("regcea_run", regcea, 1);

    // basic burst, with latency sweep instances started together
    m_ready = 1'b1;
    b  = q_d.size();
    d0 = done_n;
    run_cmd(6'd0, 7'd4, 1'b1);
    wait_done("s1_done", 50);
    chk_burst("s1", b, 6'd0, 4);
    if (q_c.size() >= b + 4) begin
      check("s1_first_latency", q_c[b] - acc_cyc, 3);
      check("s1_tput", q_c[b+3] - q_c[b], 3);
      check("s1_done_cycle", done_cyc - q_c[b+3], 1);
    end
    check("s1_done_count", done_n - d0, 1);
    check("s1_busy_after", busy, 0);
    repeat (12) @(posedge clka);
    chk_sweep("sweep_l1", 1, g_sw[0].acc, g_sw[0].first, g_sw[0].n,
              g_sw[0].lastc, g_sw[0].good);
    chk_sweep("sweep_l3", 3, g_sw[1].acc, g_sw[1].first, g_sw[1].n,
              g_sw[1].lastc, g_sw[1].good);
    chk_sweep("sweep_l5", 5, g_sw[2].acc, g_sw[2].first, g_sw[2].n,
              g_sw[2].lastc, g_sw[2].good);

    // address wrap
    b = q_d.size();
    run_cmd(6'd62, 7'd4, 1'b0);
    wait_done("wrap_done", 50);
    chk_burst("wrap", b, 6'd62, 4);

    // backpressure: 1 on / 2 off, then a long stall
    b = q_d.size();
    m_ready = 1'b0;
    run_cmd(6'd0, 7'd16, 1'b0);
    for (int i = 0; i < 12; i++) begin
      m_ready = (i % 3 == 0);
      @(posedge clka);
      #1;
    end
    m_ready = 1'b0;
    repeat (10) @(posedge clka);
    #1;
    m_ready = 1'b1;
    wait_done("bp_done", 100);
    chk_burst("bp", b, 6'd0, 16);
    check("bp_outstanding_max", out_max, 4);

    // zero length
    e0 = iss_n;
    d0 = done_n;
    run_cmd(6'd5, 7'd0, 1'b0);
    repeat (3) @(posedge clka);
    #1;
    check("len0_done", done_n - d0, 1);
    check("len0_no_ena", iss_n - e0, 0);
    check("len0_busy", busy, 0);

    // full depth
    b = q_d.size();
    run_cmd(6'd0, 7'd64, 1'b0);
    wait_done("full_done", 200);
    chk_burst("full", b, 6'd0, 64);
    if (q_c.size() >= b + 64) check("full_tput", q_c[b+63] - q_c[b], 63);

    // asynchronous reset mid-burst
    b  = q_d.size();
    run_cmd(6'd10, 7'd8, 1'b0);
    for (int i = 0; i < 30; i++) begin
      if (q_d.size() - b >= 2) break;
      @(posedge clka);
      #1;
    end
    check("mid_two_beats", q_d.size() - b >= 2, 1);
    check("mid_busy_before", busy, 1);
    #2;
    d0 = done_n;
    rsta = 1'b1;
    #1;
    check("mid_rst_m_valid", m_valid, 0);
    check("mid_rst_ena", ena, 0);
    check("mid_rst_busy", busy, 0);
    repeat (2) @(posedge clka);
    #1;
    rsta = 1'b0;
    repeat (15) @(posedge clka);
    #1;
    check("mid_no_done", done_n - d0, 0);
    check("mid_cmd_ready", cmd_ready, 1);
    b = q_d.size();
    run_cmd(6'd20, 7'd2, 1'b0);
    wait_done("post_rst_done", 50);
    chk_burst("post_rst", b, 6'd20, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
